// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: circular buffer of fetch groups between fetch and pre-decode.
// Define FETCH_QUEUE_BYPASS_EN to pass an incoming group straight to deq_* while the queue is empty.
module fetch_inst_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH       = 4,
    parameter int BRPRED_W    = 64,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [FETCH_WIDTH-1:0]        enq_lane_valid,
    input  logic [FETCH_WIDTH*32-1:0]     enq_pc,
    input  logic [FETCH_WIDTH*32-1:0]     enq_insn,
    input  logic [FETCH_WIDTH*BRPRED_W-1:0] enq_brpred,
    output logic                          enq_ready,
    output logic [FETCH_WIDTH-1:0]        deq_lane_valid,
    output logic [FETCH_WIDTH*32-1:0]     deq_pc,
    output logic [FETCH_WIDTH*32-1:0]     deq_insn,
    output logic [FETCH_WIDTH*BRPRED_W-1:0] deq_brpred,
    output logic                          deq_valid,
    input  logic                          deq_ready,
    output logic [CNT_W-1:0]              count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [FETCH_WIDTH-1:0]          laneValidMem [DEPTH];
    logic [FETCH_WIDTH*32-1:0]       pcMem        [DEPTH];
    logic [FETCH_WIDTH*32-1:0]       insnMem      [DEPTH];
    logic [FETCH_WIDTH*BRPRED_W-1:0] brpredMem    [DEPTH];
    logic [PTR_W-1:0]                headPtr, tailPtr;
    logic enqFire, deqFire, bypass, memWrite, memRead;

    assign enq_ready = count != CNT_W'(DEPTH);
    assign enqFire   = (|enq_lane_valid) && enq_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass         = enqFire && count == '0;
    assign deq_lane_valid = !deq_valid ? '0 : bypass ? enq_lane_valid : laneValidMem[headPtr];
    assign deq_pc         = bypass ? enq_pc : pcMem[headPtr];
    assign deq_insn       = bypass ? enq_insn : insnMem[headPtr];
    assign deq_brpred     = bypass ? enq_brpred : brpredMem[headPtr];
`else
    assign bypass         = 1'b0;
    assign deq_lane_valid = deq_valid ? laneValidMem[headPtr] : '0;
    assign deq_pc         = pcMem[headPtr];
    assign deq_insn       = insnMem[headPtr];
    assign deq_brpred     = brpredMem[headPtr];
`endif

    assign deq_valid = !flush && (count != '0 || bypass);
    assign deqFire   = deq_valid && deq_ready;
    // A bypassed group that is consumed immediately never touches storage.
    assign memWrite  = enqFire && !(bypass && deq_ready);
    assign memRead   = deqFire && !bypass;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (memWrite) tailPtr <= tailPtr + PTR_W'(1);
            if (memRead) headPtr <= headPtr + PTR_W'(1);
            if (memWrite && !memRead) count <= count + CNT_W'(1);
            else if (memRead && !memWrite) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (memWrite) begin
            laneValidMem[tailPtr] <= enq_lane_valid;
            pcMem[tailPtr]        <= enq_pc;
            insnMem[tailPtr]      <= enq_insn;
            brpredMem[tailPtr]    <= enq_brpred;
        end
    end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue: directed checks of the fetch instruction queue with the default parameters.
module tb_fetch_inst_queue;
    localparam int FW = 2, DEPTH = 4, BW = 64, CW = 3;

    logic clk = 1'b0;
    logic rst, flush, deq_ready, enq_ready, deq_valid;
    logic [FW-1:0]    enq_lane_valid, deq_lane_valid;
    logic [FW*32-1:0] enq_pc, enq_insn, deq_pc, deq_insn;
    logic [FW*BW-1:0] enq_brpred, deq_brpred;
    logic [CW-1:0]    count;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    fetch_inst_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .BRPRED_W(BW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_lane_valid(enq_lane_valid), .enq_pc(enq_pc), .enq_insn(enq_insn),
        .enq_brpred(enq_brpred), .enq_ready(enq_ready),
        .deq_lane_valid(deq_lane_valid), .deq_pc(deq_pc), .deq_insn(deq_insn),
        .deq_brpred(deq_brpred), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .count(count)
    );

    // Group n: lane0 pc 0x1000+8n, lane1 pc +4; distinct insn and brpred per lane.
    function automatic logic [63:0] gPc(int n);
        return {32'h1000 + 32'(n * 8) + 32'h4, 32'h1000 + 32'(n * 8)};
    endfunction
    function automatic logic [63:0] gInsn(int n);
        return {32'hA000_0000 + 32'(n * 2 + 1), 32'hA000_0000 + 32'(n * 2)};
    endfunction
    function automatic logic [127:0] gBr(int n);
        return {64'hB000_0000_0000_0000 + 64'(n * 16 + 1), 64'hB000_0000_0000_0000 + 64'(n * 16)};
    endfunction

    task automatic offer(int n, logic [1:0] lv);
        enq_lane_valid = lv;
        enq_pc         = gPc(n);
        enq_insn       = gInsn(n);
        enq_brpred     = gBr(n);
    endtask

    task automatic idle();
        enq_lane_valid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; deq_ready = 1'b0;
        offer(99, 2'b11);
        tick(); tick();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (deq_lane_valid !== 2'b00) begin errors++; $display("FAIL reset_lane_valid got=%b exp=00", deq_lane_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
    endtask

    task automatic test_fill();
        deq_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            offer(n, 2'b11);
            #1;
            checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", n, enq_ready); end
            tick();
        end
        idle();
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", enq_ready); end
        checks++; if (deq_pc !== gPc(0)) begin errors++; $display("FAIL fill_head_pc got=%h exp=%h", deq_pc, gPc(0)); end
        offer(4, 2'b11);
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_e_dropped got=%0d exp=4", count); end
    endtask

    task automatic test_drain();
        deq_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=1", n, deq_valid); end
            checks++; if (deq_lane_valid !== 2'b11) begin errors++; $display("FAIL drain_lv[%0d] got=%b exp=11", n, deq_lane_valid); end
            checks++; if (deq_pc !== gPc(n)) begin errors++; $display("FAIL drain_pc[%0d] got=%h exp=%h", n, deq_pc, gPc(n)); end
            checks++; if (deq_insn !== gInsn(n)) begin errors++; $display("FAIL drain_insn[%0d] got=%h exp=%h", n, deq_insn, gInsn(n)); end
            checks++; if (deq_brpred !== gBr(n)) begin errors++; $display("FAIL drain_br[%0d] got=%h exp=%h", n, deq_brpred, gBr(n)); end
            tick();
        end
        deq_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got=%b exp=0", deq_valid); end
        checks++; if (deq_lane_valid !== 2'b00) begin errors++; $display("FAIL drain_empty_lv got=%b exp=00", deq_lane_valid); end
    endtask

    task automatic test_lane_valid();
        deq_ready = 1'b0;
        offer(5, 2'b00);
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL lv00_count got=%0d exp=0", count); end
        offer(6, 2'b01);
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL lv01_count got=%0d exp=1", count); end
        checks++; if (deq_lane_valid !== 2'b01) begin errors++; $display("FAIL lv01_lanes got=%b exp=01", deq_lane_valid); end
        checks++; if (deq_pc !== gPc(6)) begin errors++; $display("FAIL lv01_pc got=%h exp=%h", deq_pc, gPc(6)); end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL lv01_drain got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        deq_ready = 1'b0;
        for (int n = 10; n < 13; n++) begin
            offer(n, 2'b11);
            tick();
        end
        idle();
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        offer(13, 2'b11);
        deq_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL flush_same_valid got=%b exp=0", deq_valid); end
        checks++; if (deq_lane_valid !== 2'b00) begin errors++; $display("FAIL flush_same_lv got=%b exp=00", deq_lane_valid); end
        tick();
        flush = 1'b0;
        deq_ready = 1'b0;
        idle();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", deq_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", enq_ready); end
    endtask

    task automatic test_back_to_back();
        deq_ready = 1'b0;
        offer(20, 2'b11);
        tick();
        deq_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            offer(21 + k, 2'b11);
            #1;
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=1", k, count); end
            checks++; if (deq_pc !== gPc(20 + k)) begin errors++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, deq_pc, gPc(20 + k)); end
            tick();
        end
        idle();
        #1;
        checks++; if (deq_insn !== gInsn(20 + 2 * DEPTH)) begin errors++; $display("FAIL b2b_last got=%h exp=%h", deq_insn, gInsn(20 + 2 * DEPTH)); end
        tick();
        deq_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end got=%0d exp=0", count); end
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        deq_ready = 1'b1;
        offer(30, 2'b11);
        #1;
        checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got=%b exp=1", deq_valid); end
        checks++; if (deq_pc !== gPc(30)) begin errors++; $display("FAIL byp_pc got=%h exp=%h", deq_pc, gPc(30)); end
        tick();
        idle();
        deq_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL byp_after got=%b exp=0", deq_valid); end
    endtask
`else
    task automatic test_latency();
        deq_ready = 1'b1;
        offer(31, 2'b11);
        #1;
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL lat_same got=%b exp=0", deq_valid); end
        tick();
        idle();
        #1;
        checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL lat_next got=%b exp=1", deq_valid); end
        checks++; if (deq_pc !== gPc(31)) begin errors++; $display("FAIL lat_pc got=%h exp=%h", deq_pc, gPc(31)); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL lat_count got=%0d exp=1", count); end
        tick();
        deq_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL lat_drain got=%0d exp=0", count); end
    endtask
`endif

    task automatic test_reset_midop();
        deq_ready = 1'b0;
        offer(40, 2'b11); tick();
        offer(41, 2'b11); tick();
        offer(42, 2'b11);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        idle();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", deq_valid); end
        offer(43, 2'b10);
        tick();
        idle();
        #1;
        checks++; if (deq_pc !== gPc(43) || deq_lane_valid !== 2'b10) begin errors++; $display("FAIL rstmid_head got=%h/%b exp=%h/10", deq_pc, deq_lane_valid, gPc(43)); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_lane_valid();
        test_flush();
        test_back_to_back();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`else
        test_latency();
`endif
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
